// File: rtl/vreg_pkg.sv
// Shared types and constants for the vector register file context-save path.
package vreg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SEND = 2'd2,
    FIN  = 2'd3
  } state_e;

  localparam int unsigned NREGS      = 32;
  localparam int unsigned DW         = 64;
  localparam int unsigned VREG_BYTES = 8;

endpackage

// File: rtl/prio_enc_lsb.sv
// Lowest-set-bit encoder: binary index, one-hot isolate and any-set flag.
module prio_enc_lsb #(
  parameter int unsigned N  = 32,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  onehot,
  output logic          any
);

  // Two's-complement isolate keeps the index OR-tree free of a priority chain.
  always_comb begin
    onehot = req & (~req + N'(1));
    any    = |req;
    idx    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (onehot[i]) idx = idx | IW'(i);
    end
  end

endmodule

// File: rtl/vreg_ctx_save.sv
// Context-save engine: drains masked vector registers to memory over valid/ready.
module vreg_ctx_save #(
  parameter int unsigned NREGS  = 32,
  parameter int unsigned DW     = 64,
  parameter int unsigned MAW    = 32,
  parameter int unsigned STRIDE = 8
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     START,
  input  logic [MAW-1:0]           BASE_ADDR,
  input  logic [NREGS-1:0]         MASK,
  output logic                     BUSY,
  output logic                     DONE,
  output logic [$clog2(NREGS):0]   COUNT,
  output logic [$clog2(NREGS)-1:0] RF_Addr,
  input  logic [DW-1:0]            RF_Data,
  output logic                     M_VALID,
  input  logic                     M_READY,
  output logic [MAW-1:0]           M_ADDR,
  output logic [DW-1:0]            M_DATA
);

  import vreg_pkg::*;

  localparam int unsigned IW = $clog2(NREGS);
  localparam int unsigned CW = IW + 1;

  state_e           state_q, state_d;
  logic [NREGS-1:0] pend_q, pend_d;
  logic [MAW-1:0]   base_q, base_d;
  logic [CW-1:0]    count_q, count_d;
  logic             m_valid_q, m_valid_d;
  logic [MAW-1:0]   m_addr_q, m_addr_d;
  logic [DW-1:0]    m_data_q, m_data_d;

  logic [IW-1:0]    lo_idx;
  logic [NREGS-1:0] lo_onehot;
  logic             lo_any;
  logic [MAW-1:0]   beat_addr;
  logic             load;

  prio_enc_lsb #(
    .N  (NREGS),
    .IW (IW)
  ) u_enc (
    .req    (pend_q),
    .idx    (lo_idx),
    .onehot (lo_onehot),
    .any    (lo_any)
  );

  assign RF_Addr   = lo_idx;
  assign beat_addr = base_q + MAW'(lo_idx) * MAW'(STRIDE);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      base_q    <= '0;
      count_q   <= '0;
      m_valid_q <= 1'b0;
      m_addr_q  <= '0;
      m_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      base_q    <= base_d;
      count_q   <= count_d;
      m_valid_q <= m_valid_d;
      m_addr_q  <= m_addr_d;
      m_data_q  <= m_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (START) state_d = SCAN;
      SCAN:    state_d = lo_any ? SEND : FIN;
      SEND:    if (M_READY && !lo_any) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A beat is loaded from SCAN or, back-to-back, on an accepted handshake in SEND.
  always_comb begin
    pend_d    = pend_q;
    base_d    = base_q;
    count_d   = count_q;
    m_valid_d = m_valid_q;
    m_addr_d  = m_addr_q;
    m_data_d  = m_data_q;
    load      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          pend_d  = MASK;
          base_d  = BASE_ADDR;
          count_d = '0;
        end
      end
      SCAN: load = lo_any;
      SEND: begin
        if (M_READY) begin
          count_d = count_q + CW'(1);
          load    = lo_any;
          if (!lo_any) m_valid_d = 1'b0;
        end
      end
      default: ;
    endcase
    if (load) begin
      m_data_d  = RF_Data;
      m_addr_d  = beat_addr;
      m_valid_d = 1'b1;
      pend_d    = pend_q & ~lo_onehot;
    end
  end

  always_comb begin
    BUSY    = (state_q != IDLE);
    DONE    = (state_q == FIN);
    COUNT   = count_q;
    M_VALID = m_valid_q;
    M_ADDR  = m_addr_q;
    M_DATA  = m_data_q;
  end

endmodule

// File: tb/tb_vreg_ctx_save.sv
// Self-checking bench for vreg_ctx_save with a register-file model and beat scoreboard.
module tb_vreg_ctx_save;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [31:0] BASE_ADDR;
  logic [31:0] MASK;
  logic        BUSY;
  logic        DONE;
  logic [5:0]  COUNT;
  logic [4:0]  RF_Addr;
  logic [63:0] RF_Data;
  logic        M_VALID;
  logic        M_READY;
  logic [31:0] M_ADDR;
  logic [63:0] M_DATA;

  logic [63:0] rf [32];
  assign RF_Data = rf[RF_Addr];

  always #5 CLK = ~CLK;

  vreg_ctx_save #(
    .NREGS  (32),
    .DW     (64),
    .MAW    (32),
    .STRIDE (8)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .BASE_ADDR (BASE_ADDR),
    .MASK      (MASK),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .COUNT     (COUNT),
    .RF_Addr   (RF_Addr),
    .RF_Data   (RF_Data),
    .M_VALID   (M_VALID),
    .M_READY   (M_READY),
    .M_ADDR    (M_ADDR),
    .M_DATA    (M_DATA)
  );

  typedef struct {
    logic [31:0] mask;
    logic [31:0] base;
    logic [63:0] seed;
    int unsigned stall;
    bit          poke;
    int unsigned exp_count;
    int unsigned exp_done;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
  } beat_t;

  vec_t  vecs [6];
  beat_t sbq [$];
  int    checks   = 0;
  int    failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after a rising edge.
  task automatic run_save(input vec_t v);
    beat_t       b;
    int unsigned stalled;
    int unsigned hs;
    bit          done_seen;
    for (int i = 0; i < 32; i++) rf[i] = v.seed + 64'(i);
    for (int i = 0; i < 32; i++) begin
      if (v.mask[i]) begin
        b.addr = v.base + 32'(i) * 32'd8;
        b.data = v.seed + 64'(i);
        sbq.push_back(b);
      end
    end
    START     = 1'b1;
    MASK      = v.mask;
    BASE_ADDR = v.base;
    M_READY   = (v.stall == 0);
    @(posedge CLK);
    #1 START  = 1'b0;
    stalled   = 0;
    hs        = 0;
    done_seen = 1'b0;
    for (int unsigned cyc = 0; cyc < 200 && !done_seen; cyc++) begin
      @(negedge CLK);
      if (cyc == 0) chk("busy_after_start", 64'(BUSY), 64'd1);
      if (M_VALID && !M_READY) begin
        if (stalled < v.stall) begin
          stalled++;
          if (sbq.size() > 0) begin
            chk("stall_addr", 64'(M_ADDR), 64'(sbq[0].addr));
            chk("stall_data", M_DATA, sbq[0].data);
          end
          if (v.poke && stalled == 1) rf[3] = 64'hDEAD_BEEF_0000_0003;
        end else begin
          M_READY = 1'b1;
        end
      end
      if (M_VALID && M_READY) begin
        if (sbq.size() == 0) begin
          chk("beat_unexpected", 64'd1, 64'd0);
        end else begin
          b = sbq.pop_front();
          chk("beat_addr", 64'(M_ADDR), 64'(b.addr));
          chk("beat_data", M_DATA, b.data);
          hs++;
        end
      end
      if (DONE) begin
        done_seen = 1'b1;
        chk("done_cycle", 64'(cyc), 64'(v.exp_done));
        chk("done_count", 64'(COUNT), 64'(v.exp_count));
        chk("handshakes", 64'(hs), 64'(v.exp_count));
      end
    end
    if (!done_seen) chk("done_timeout", 64'd0, 64'd1);
    chk("queue_empty", 64'(sbq.size()), 64'd0);
    sbq.delete();
    @(negedge CLK);
    chk("done_pulse_width", 64'(DONE), 64'd0);
    chk("busy_after_done", 64'(BUSY), 64'd0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t fresh;
    vecs[0] = '{32'h0000_0005, 32'h0000_1000, 64'hA,     0, 1'b0, 2,  3};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FF80, 64'h0,     0, 1'b0, 32, 33};
    vecs[2] = '{32'h8000_0001, 32'h0000_2000, 64'h100,   5, 1'b0, 2,  8};
    vecs[3] = '{32'h0000_0000, 32'h0000_3000, 64'h0,     0, 1'b0, 0,  1};
    vecs[4] = '{32'h0000_0008, 32'h0000_4000, 64'h55,    3, 1'b1, 1,  5};
    vecs[5] = '{32'h00F0_0F00, 32'h0000_0010, 64'h777,   0, 1'b0, 8,  9};
    fresh   = '{32'h0000_0006, 32'h0000_0600, 64'h40,    0, 1'b0, 2,  3};

    for (int i = 0; i < 32; i++) rf[i] = 64'(i);
    RESET = 1'b0; START = 1'b0; MASK = '0; BASE_ADDR = '0; M_READY = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy",    64'(BUSY),    64'd0);
    chk("rst_done",    64'(DONE),    64'd0);
    chk("rst_mvalid",  64'(M_VALID), 64'd0);
    chk("rst_count",   64'(COUNT),   64'd0);
    chk("rst_maddr",   64'(M_ADDR),  64'd0);
    chk("rst_mdata",   M_DATA,       64'd0);
    chk("rst_rf_addr", 64'(RF_Addr), 64'd0);
    RESET = 1'b1;
    @(posedge CLK);
    #1;

    foreach (vecs[k]) run_save(vecs[k]);

    // START while busy is ignored; reset during SEND aborts the save.
    for (int i = 0; i < 32; i++) rf[i] = 64'h900 + 64'(i);
    START = 1'b1; MASK = 32'h3; BASE_ADDR = 32'h500; M_READY = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    @(posedge CLK);
    #1 START = 1'b1; MASK = '1; BASE_ADDR = 32'hABC0;
    @(posedge CLK);
    #1 START = 1'b0; M_READY = 1'b0;
    @(negedge CLK);
    chk("busy_start_count", 64'(COUNT),   64'd1);
    chk("busy_start_valid", 64'(M_VALID), 64'd1);
    chk("busy_start_addr",  64'(M_ADDR),  64'h508);
    chk("busy_start_data",  M_DATA,       64'h901);
    RESET = 1'b0;
    @(posedge CLK);
    #1 RESET = 1'b1;
    @(negedge CLK);
    chk("abort_mvalid", 64'(M_VALID), 64'd0);
    chk("abort_busy",   64'(BUSY),    64'd0);
    chk("abort_count",  64'(COUNT),   64'd0);
    chk("abort_done",   64'(DONE),    64'd0);
    chk("abort_maddr",  64'(M_ADDR),  64'd0);
    @(posedge CLK);
    #1;
    run_save(fresh);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
